// File: rtl/gpio_ctrl_intr_arbiter_if.sv
// APB write-only master bus from the interrupt arbiter to the GPIO status CSR.
// Carries the one-hot W1C clear word; m_pready stalls the master.
interface gpio_ctrl_intr_arbiter_if;
  logic        m_psel;
  logic        m_penable;
  logic        m_pwrite;
  logic [3:0]  m_pstrb;
  logic [31:0] m_pwdata;
  logic        m_pready;
  logic        m_pslverr;

  modport master (
    output m_psel, m_penable, m_pwrite, m_pstrb, m_pwdata,
    input  m_pready, m_pslverr
  );

  modport slave (
    input  m_psel, m_penable, m_pwrite, m_pstrb, m_pwdata,
    output m_pready, m_pslverr
  );
endinterface

// File: rtl/gpio_ctrl_intr_arbiter.sv
// Round-robin GPIO bank interrupt arbiter; irq follows eligible by one cycle, clear is an APB W1C write.
// Holds irq until irq_ack; stalls on m_pready up to TIMEOUT access cycles, then abandons and flags clr_err.
module gpio_ctrl_intr_arbiter #(
  parameter int NUM_BANKS = 4,
  parameter int ID_W      = $clog2(NUM_BANKS),
  parameter int TIMEOUT   = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_BANKS-1:0]   intr_pending,
  input  logic [NUM_BANKS-1:0]   intr_enable,
  output logic                   irq,
  output logic [ID_W-1:0]        irq_id,
  input  logic                   irq_ack,
  gpio_ctrl_intr_arbiter_if.master apb,
  output logic                   busy,
  output logic                   clr_err,
  input  logic                   clr_err_clr
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PRESENT = 2'd1;
  localparam logic [1:0] S_SETUP   = 2'd2;
  localparam logic [1:0] S_ACCESS  = 2'd3;

  localparam logic [7:0]    TIMEOUT_C = 8'(TIMEOUT);
  localparam logic [ID_W:0] NB_C      = (ID_W+1)'(NUM_BANKS);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_BANKS - 1);

  logic [1:0]             state;
  logic [ID_W-1:0]        rr_ptr;
  logic [7:0]             wait_cnt;
  logic [7:0]             cnt_nxt;
  logic [NUM_BANKS-1:0]   eligible;
  logic [2*NUM_BANKS-1:0] dbl;
  logic [NUM_BANKS-1:0]   rot;
  logic [ID_W-1:0]        off;
  logic [ID_W:0]          gsum;
  logic                   grant_vld;
  logic [ID_W-1:0]        grant_id;
  logic [ID_W-1:0]        rr_next;
  logic                   unused_pslverr;

  assign unused_pslverr = apb.m_pslverr;
  assign eligible       = intr_pending & intr_enable;
  assign cnt_nxt        = wait_cnt + 8'd1;
  assign rr_next        = (irq_id == LAST_ID) ? '0 : irq_id + 1'b1;

  // Rotate so rr_ptr lands at bit 0; the lowest set bit is then the offset from rr_ptr.
  always_comb begin
    dbl       = {eligible, eligible} >> rr_ptr;
    rot       = dbl[NUM_BANKS-1:0];
    off       = '0;
    grant_vld = |rot;
    for (int i = NUM_BANKS - 1; i >= 0; i--) begin
      if (rot[i]) off = ID_W'(i);
    end
    gsum = {1'b0, rr_ptr} + {1'b0, off};
    if (gsum >= NB_C) gsum = gsum - NB_C;
    grant_id = gsum[ID_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      rr_ptr        <= '0;
      wait_cnt      <= '0;
      irq           <= 1'b0;
      irq_id        <= '0;
      busy          <= 1'b0;
      clr_err       <= 1'b0;
      apb.m_psel    <= 1'b0;
      apb.m_penable <= 1'b0;
      apb.m_pwrite  <= 1'b0;
      apb.m_pstrb   <= 4'h0;
      apb.m_pwdata  <= 32'h0;
    end else begin
      // A timeout in the same cycle overrides this clear further down.
      if (clr_err_clr) clr_err <= 1'b0;

      case (state)
        S_IDLE: begin
          if (grant_vld) begin
            irq    <= 1'b1;
            irq_id <= grant_id;
            busy   <= 1'b1;
            state  <= S_PRESENT;
          end
        end
        S_PRESENT: begin
          if (irq_ack) begin
            irq           <= 1'b0;
            apb.m_psel    <= 1'b1;
            apb.m_penable <= 1'b0;
            apb.m_pwrite  <= 1'b1;
            apb.m_pstrb   <= 4'hF;
            apb.m_pwdata  <= 32'd1 << irq_id;
            state         <= S_SETUP;
          end
        end
        S_SETUP: begin
          apb.m_penable <= 1'b1;
          wait_cnt      <= '0;
          state         <= S_ACCESS;
        end
        S_ACCESS: begin
          if (apb.m_pready || (cnt_nxt == TIMEOUT_C)) begin
            apb.m_psel    <= 1'b0;
            apb.m_penable <= 1'b0;
            apb.m_pwrite  <= 1'b0;
            apb.m_pstrb   <= 4'h0;
            apb.m_pwdata  <= 32'h0;
            wait_cnt      <= '0;
            rr_ptr        <= rr_next;
            busy          <= 1'b0;
            state         <= S_IDLE;
            if (!apb.m_pready) clr_err <= 1'b1;
          end else begin
            wait_cnt <= cnt_nxt;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/gpio_ctrl_intr_arbiter.md
Name: gpio_ctrl_intr_arbiter

Overview:
Sits between the per-bank interrupt status CSR and the CPU interrupt line.
- Masks the per-bank pending bits and picks one bank by round-robin.
- Presents a single IRQ plus the bank ID, and waits for a CPU acknowledge.
- Then acts as an APB master and writes a one-hot W1C word into the status CSR to clear the serviced bank.
- The clear path lets firmware acknowledge through a single ack strobe instead of its own status-CSR write.

Parameters:
NUM_BANKS, 4, number of GPIO banks / interrupt sources (2..32)
ID_W, $clog2(NUM_BANKS), width of irq_id
TIMEOUT, 15, max ACCESS-phase cycles waiting for pready before abandoning a clear (1..255)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
intr_pending  in  NUM_BANKS  per-bank status from the status CSR interrupt output
intr_enable  in  NUM_BANKS  per-bank enable mask, static config
irq  out  1  interrupt request to CPU
irq_id  out  ID_W  bank being presented, valid while irq=1
irq_ack  in  1  CPU acknowledge pulse, honoured only while irq=1
m_psel  out  1  APB master select to status CSR
m_penable  out  1  APB master enable
m_pwrite  out  1  APB write, always 1 when m_psel=1
m_pstrb  out  4  APB strobes, 4'hF when m_psel=1
m_pwdata  out  32  one-hot clear word
m_pready  in  1  APB ready from status CSR
m_pslverr  in  1  APB error, ignored
busy  out  1  high in any state other than IDLE
clr_err  out  1  sticky: a clear timed out
clr_err_clr  in  1  clears clr_err

Behaviour:
- Clock and reset: single clock clk; rst_n asynchronous, active low.
- Reset values:
  - State IDLE; rr_ptr=0.
  - irq=0, irq_id=0.
  - m_psel=0, m_penable=0, m_pwrite=0, m_pstrb=0, m_pwdata=0.
  - busy=0, clr_err=0, wait counter=0.
  - Reset mid-transaction aborts immediately with no completion.
- All outputs are registered.
- eligible = intr_pending & intr_enable.
- IDLE:
  - If eligible!=0, grant the first set bit scanning upward from rr_ptr, with wrap.
  - Register irq=1 and irq_id=grant; go to PRESENT.
  - Latency: eligible high in cycle N gives irq=1 in cycle N+1.
- PRESENT:
  - irq and irq_id are held stable.
  - Deasserting the enable or pending bit does not withdraw a presented interrupt.
  - On irq_ack=1: irq<=0; go to SETUP.
  - irq_ack outside PRESENT is ignored.
- SETUP (one cycle):
  - m_psel=1, m_penable=0, m_pwrite=1, m_pstrb=4'hF, m_pwdata=1<<irq_id.
  - Go to ACCESS; wait counter=0.
- ACCESS:
  - m_psel=1, m_penable=1; address, data and control held.
  - On m_pready=1 sampled: drop m_psel, m_penable and m_pwdata to 0.
  - Same edge: rr_ptr=(irq_id+1) mod NUM_BANKS, with wrap at NUM_BANKS-1 to 0; go to IDLE.
  - If the counter reaches TIMEOUT without m_pready:
    - Drop the bus and set clr_err=1.
    - Advance rr_ptr the same way; go to IDLE.
- The status CSR may raise pready during SETUP; only pready sampled in ACCESS completes the transfer.
- IDLE may grant in the cycle directly after ACCESS completes. The status bit is already cleared by then.
- A new edge arriving in the same cycle as the clear re-sets the bit in the CSR. The arbiter treats it as new pending and services it normally.
- If clr_err_clr and a timeout occur in the same cycle, the set wins.
- At most one bank is outstanding at any time.
- Fairness: with all banks continuously eligible, grants rotate 0,1,2,...,NUM_BANKS-1,0.

Test Plan:
- Single source: reset, intr_enable=4'hF, pulse intr_pending[2] to 1 at cycle 10 → irq=1 and irq_id=2 at cycle 11. ack at cycle 14 → SETUP at 15 with m_pwdata=32'h4, ACCESS at 16; pready sampled → busy=0 next cycle.
- Round-robin: intr_pending=4'hF held, ack each IRQ promptly → irq_id sequence 0,1,2,3,0. Then, with only banks 1 and 3 pending after servicing 3, next grant is 1.
- Masking: intr_pending=4'b0101, intr_enable=4'b0100 → only irq_id=2 ever presented. Bank 0 never granted until intr_enable[0]=1.
- Hold: while PRESENT with irq_id=1, drop intr_enable[1] and pulse irq_ack only 20 cycles later → irq stays 1 with id 1 for all 20 cycles, then the clear write of 32'h2 is issued.
- Timeout: slave holds m_pready=0 → bus released after 15 ACCESS cycles, clr_err=1, return to IDLE. clr_err_clr pulse → clr_err=0.
- Async reset asserted during ACCESS → all outputs 0 immediately. After release, pending bank is re-granted starting from rr_ptr=0.
